posit_decode_pipe: RTL and testbench
====================================

POSIT_DECODE_PIPE -- requirements
Module: posit_decode_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, total posit width; legal range 4..32.
REQ-002 SHALL have parameter ES, default 1, exponent field width; legal range 0..4.
REQ-003 SHALL derive FB = max(WIDTH-3-ES, 1); RB = clog2(WIDTH-1)+1; EB = RB+ES; BIAS = 2^ES*(WIDTH-2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  in_posit holds a valid posit.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 in_posit  input  WIDTH  packed posit.
REQ-010 out_valid  output  1  decoded result present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_isZero  output  1  input was all zeros.
REQ-013 out_isInf  output  1  input was 1 followed by WIDTH-1 zeros.
REQ-014 out_sign  output  1  posit sign bit.
REQ-015 out_exp  output  EB  unsigned biased exponent.
REQ-016 out_frac  output  FB  fraction without hidden bit, MSB-aligned.

Function
REQ-017 SHALL be a 2-stage pipeline: S1 registers sign, zero/inf flags, two's-complement magnitude and regime run length; S2 registers the exponent and fraction.
REQ-018 Handshake: transfer occurs when valid&&ready on the same edge; valid SHALL NOT depend combinationally on ready.
REQ-019 S2 accepts when !s2_valid || out_ready; S1 accepts when !s1_valid || S2 accepts; in_ready = S1 accepts.
REQ-020 Latency: 2 cycles from input transfer to out_valid with no stalls; throughput 1 per cycle.
REQ-021 Held results SHALL stay stable while out_valid && !out_ready; no data is lost or duplicated under any stall pattern.
REQ-022 Magnitude m = sign ? -in_posit[WIDTH-2:0] : in_posit[WIDTH-2:0] (WIDTH-1 bits).
REQ-023 Regime: r0 = m MSB; k = run length of bits equal to r0 (1..WIDTH-1); signed regime R = r0 ? k-1 : -k.
REQ-024 After the run, skip one terminating bit (if present); the next ES bits form e, zero-padded on the right if truncated.
REQ-025 Remaining bits SHALL form out_frac, left-aligned and zero-padded to FB bits; excess bits never occur.
REQ-026 out_exp = R*2^ES + e + BIAS, always in 0..2*BIAS, fits EB bits unsigned.
REQ-027 For isZero or isInf: out_sign = in_posit MSB, out_exp = 0, out_frac = 0.
REQ-028 Boundary: m all ones gives out_exp = 2*BIAS; m = 1 gives out_exp = 0.

Reset
REQ-029 While resetn low: in_ready = 0, out_valid = 0, s1_valid = 0, s2_valid = 0; data registers = 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight results; first transfer after release is accepted on the first rising edge with resetn high.
REQ-031 out_valid SHALL remain 0 for at least 2 cycles after reset release.

Verification (WIDTH=8, ES=1: FB=4, EB=5, BIAS=12)
REQ-032 in 0x40, out_ready=1 -> 2 cycles later sign 0, exp 12, frac 0000, flags 0.
REQ-033 Back-to-back 0x48, 0xC0, 0x00, 0x80 -> (0,12,1000), (1,12,0000), isZero=1, isInf=1 (sign 1, exp 0, frac 0) on consecutive cycles.
REQ-034 in 0x7F then 0x01 -> exp 24 frac 0; exp 0 frac 0.
REQ-035 out_ready=0 for 5 cycles with in_valid continuously 1 -> in_ready drops after 2 accepts, out data stable, all values emerge in order after release.
REQ-036 resetn pulsed low with 2 items in flight -> out_valid=0 immediately, no stale result after release.
REQ-037 Random WIDTH=16 ES=2 sweep with random stalls vs. reference decoder model -> zero mismatches.

Source files
------------

// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder: stage 1 extracts sign, special flags, magnitude and
// regime run length; stage 2 produces the biased exponent and aligned fraction.
module posit_decode_pipe #(
  parameter int WIDTH = 8,
  parameter int ES = 1,
  localparam int FB = ((WIDTH - 3 - ES) > 1) ? (WIDTH - 3 - ES) : 1,
  localparam int RB = $clog2(WIDTH - 1) + 1,
  localparam int EB = RB + ES
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_posit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_isZero,
  output logic             out_isInf,
  output logic             out_sign,
  output logic [EB-1:0]    out_exp,
  output logic [FB-1:0]    out_frac
);

  localparam int MW   = WIDTH - 1;
  localparam int TW   = ES + FB;
  localparam int XW   = MW + TW;
  localparam int BIAS = (1 << ES) * (WIDTH - 2);

  // Handshake: a beat moves across any boundary on a rising edge where valid
  // and ready are both high. valid never looks at ready; ready flows backward
  // (a stage is ready when empty or when the stage after it is draining).
  logic s1_valid, s2_valid;
  logic s1_accept, s2_accept;

  assign s2_accept = !s2_valid || out_ready;
  assign s1_accept = !s1_valid || s2_accept;
  assign in_ready  = resetn && s1_accept;

  // ---------------- stage 1 combinational ----------------
  logic [MW-1:0] mag_c;
  logic          zero_c, inf_c;
  logic [RB-1:0] k_c;
  logic          run_c;

  always_comb begin
    mag_c  = in_posit[MW-1:0];
    if (in_posit[WIDTH-1])
      mag_c = ~in_posit[MW-1:0] + MW'(1);
    zero_c = (in_posit == '0);
    inf_c  = in_posit[WIDTH-1] && (in_posit[MW-1:0] == '0);
    run_c  = 1'b1;
    k_c    = '0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (run_c && (mag_c[i] == mag_c[MW-1]))
        k_c = k_c + RB'(1);
      else
        run_c = 1'b0;
    end
  end

  logic          s1_sign, s1_zero, s1_inf;
  logic [MW-1:0] s1_mag;
  logic [RB-1:0] s1_k;

  // ---------------- stage 2 combinational ----------------
  logic [XW-1:0] sh_c;
  logic [TW-1:0] top_c;
  logic [EB-1:0] kx_c, e_c, exp_c;
  logic [FB-1:0] frac_c;

  // Dropping the run plus its terminator leaves exponent bits then fraction
  // bits at the top; the zero tail supplies right-padding when truncated.
  // Exponent math wraps modulo 2^EB; the final value is always in range.
  always_comb begin
    sh_c   = {s1_mag, {TW{1'b0}}} << (int'(s1_k) + 1);
    top_c  = sh_c[XW-1 -: TW];
    frac_c = top_c[FB-1:0];
    e_c    = EB'(top_c >> FB);
    kx_c   = EB'(s1_k);
    if (s1_mag[MW-1])
      exp_c = ((kx_c - EB'(1)) << ES) + e_c + EB'(BIAS);
    else
      exp_c = EB'(BIAS) - (kx_c << ES) + e_c;
    if (s1_zero || s1_inf) begin
      exp_c  = '0;
      frac_c = '0;
    end
  end

  logic          s2_sign, s2_zero, s2_inf;
  logic [EB-1:0] s2_exp;
  logic [FB-1:0] s2_frac;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_mag   <= '0;
      s1_k     <= '0;
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_inf   <= 1'b0;
      s2_exp   <= '0;
      s2_frac  <= '0;
    end else begin
      if (s1_accept) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_posit[WIDTH-1];
          s1_zero <= zero_c;
          s1_inf  <= inf_c;
          s1_mag  <= mag_c;
          s1_k    <= k_c;
        end
      end
      if (s2_accept) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sign <= s1_sign;
          s2_zero <= s1_zero;
          s2_inf  <= s1_inf;
          s2_exp  <= exp_c;
          s2_frac <= frac_c;
        end
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_isZero = s2_zero;
  assign out_isInf  = s2_inf;
  assign out_sign   = s2_sign;
  assign out_exp    = s2_exp;
  assign out_frac   = s2_frac;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Bench for posit_decode_pipe: directed 8-bit/ES=1 vectors with hand-computed
// results, plus a 16-bit/ES=2 sweep against an independent bit-walking decoder.
module tb_posit_decode_pipe;

  logic clock;
  logic resetn;

  // 8-bit, ES=1 instance: FB=4, EB=5, BIAS=12
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_posit8;
  logic        zero8, inf8, sign8;
  logic [4:0]  exp8;
  logic [3:0]  frac8;
  logic [11:0] obs8;

  // 16-bit, ES=2 instance: FB=11, EB=7, BIAS=56
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] in_posit16;
  logic        zero16, inf16, sign16;
  logic [6:0]  exp16;
  logic [10:0] frac16;
  logic [20:0] obs16;

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];

  assign obs8  = {zero8, inf8, sign8, exp8, frac8};
  assign obs16 = {zero16, inf16, sign16, exp16, frac16};

  posit_decode_pipe #(.WIDTH(8), .ES(1)) u_dut8 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_posit(in_posit8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_isZero(zero8), .out_isInf(inf8), .out_sign(sign8),
    .out_exp(exp8), .out_frac(frac8)
  );

  posit_decode_pipe #(.WIDTH(16), .ES(2)) u_dut16 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_posit(in_posit16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_isZero(zero16), .out_isInf(inf16), .out_sign(sign16),
    .out_exp(exp16), .out_frac(frac16)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: walk the magnitude bit by bit like reading the posit by hand.
  function automatic logic [20:0] ref16(input logic [15:0] p);
    logic [14:0] m;
    logic        r0;
    int          i, k, e, f, r, ex;
    if (p == 16'h0000) return {1'b1, 1'b0, 1'b0, 7'd0, 11'd0};
    if (p == 16'h8000) return {1'b0, 1'b1, 1'b1, 7'd0, 11'd0};
    m = p[14:0];
    if (p[15]) m = ~m + 15'd1;
    r0 = m[14];
    i = 14;
    k = 0;
    while (i >= 0) begin
      if (m[i] != r0) break;
      k++;
      i--;
    end
    if (i >= 0) i--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((i >= 0) ? int'(m[i]) : 0);
      i--;
    end
    f = 0;
    for (int j = 0; j < 11; j++) begin
      f = f * 2 + ((i >= 0) ? int'(m[i]) : 0);
      i--;
    end
    r  = r0 ? k - 1 : -k;
    ex = r * 4 + e + 56;
    return {1'b0, 1'b0, p[15], 7'(ex), 11'(f)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (in_ready8 !== 1'b0 || out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: in_ready=%b out_valid=%b required 0 0", in_ready8, out_valid8);
    end
    checks++;
    if (in_ready16 !== 1'b0 || out_valid16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: in_ready=%b out_valid=%b required 0 0", in_ready16, out_valid16);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (out_valid8 !== 1'b0 || out_valid16 !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_valid c=%0d: got %b %b required 0 0", c, out_valid8, out_valid16);
      end
      @(negedge clock);
    end
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b required 1", in_ready8);
    end
  endtask

  task automatic test_single();
    @(negedge clock);
    out_ready8 = 1'b1;
    in_valid8  = 1'b1;
    in_posit8  = 8'h40;
    #1;
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b required 1", in_ready8);
    end
    @(negedge clock);
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL single_latency1: out_valid=%b required 0", out_valid8);
    end
    @(negedge clock);
    checks++;
    if (out_valid8 !== 1'b1 || obs8 !== 12'h0C0) begin
      errors++;
      $display("FAIL single_0x40: valid=%b got %h required %h", out_valid8, obs8, 12'h0C0);
    end
    @(negedge clock);
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: out_valid=%b required 0", out_valid8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vec [4];
    logic [11:0] expv[4];
    vec  = '{8'h48, 8'hC0, 8'h00, 8'h80};
    expv = '{12'h0C8, 12'h2C0, 12'h800, 12'h600};
    out_ready8 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      checks++;
      if (c >= 2 && c < 6) begin
        if (out_valid8 !== 1'b1 || obs8 !== expv[c-2]) begin
          errors++;
          $display("FAIL b2b[%0d]: valid=%b got %h required %h", c - 2, out_valid8, obs8, expv[c-2]);
        end
      end else if (out_valid8 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle c=%0d: out_valid=%b required 0", c, out_valid8);
      end
      in_valid8 = (c < 4);
      if (c < 4) in_posit8 = vec[c];
    end
  endtask

  task automatic test_extremes();
    logic [7:0]  vec [6];
    logic [11:0] expv[6];
    vec  = '{8'h7F, 8'h01, 8'h60, 8'h30, 8'h5A, 8'hFF};
    expv = '{12'h180, 12'h000, 12'h0E0, 12'h0B0, 12'h0DA, 12'h200};
    out_ready8 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      if (c >= 2 && c < 8) begin
        checks++;
        if (out_valid8 !== 1'b1 || obs8 !== expv[c-2]) begin
          errors++;
          $display("FAIL extreme in=%h: valid=%b got %h required %h", vec[c-2], out_valid8, obs8, expv[c-2]);
        end
      end
      in_valid8 = (c < 6);
      if (c < 6) in_posit8 = vec[c];
    end
    in_valid8 = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0]  vec [4];
    logic [11:0] expv[4];
    int idx, oidx;
    vec  = '{8'h48, 8'hC0, 8'h5A, 8'h30};
    expv = '{12'h0C8, 12'h2C0, 12'h0DA, 12'h0B0};
    idx  = 0;
    oidx = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      out_ready8 = (c >= 5);
      in_valid8  = (idx < 4);
      if (idx < 4) in_posit8 = vec[idx];
      #1;
      if (c < 5) begin
        checks++;
        if (in_ready8 !== (c < 2)) begin
          errors++;
          $display("FAIL stall_ready c=%0d: got %b required %b", c, in_ready8, (c < 2));
        end
      end
      if (c >= 2 && c < 5) begin
        checks++;
        if (out_valid8 !== 1'b1 || obs8 !== expv[0]) begin
          errors++;
          $display("FAIL stall_hold c=%0d: valid=%b got %h required %h", c, out_valid8, obs8, expv[0]);
        end
      end
      if (out_valid8 && out_ready8) begin
        checks++;
        if (oidx >= 4) begin
          errors++;
          $display("FAIL stall_extra: got %h required none", obs8);
        end else if (obs8 !== expv[oidx]) begin
          errors++;
          $display("FAIL stall_order[%0d]: got %h required %h", oidx, obs8, expv[oidx]);
        end
        oidx++;
      end
      if (in_valid8 && in_ready8) idx++;
    end
    in_valid8 = 1'b0;
    checks++;
    if (oidx != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d outputs required 4", oidx);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clock);
    out_ready8 = 1'b0;
    in_valid8  = 1'b1;
    in_posit8  = 8'h48;
    @(negedge clock);
    in_posit8 = 8'h40;
    @(negedge clock);
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b1) begin
      errors++;
      $display("FAIL midflight_setup: out_valid=%b required 1", out_valid8);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset: out_valid=%b in_ready=%b required 0 0", out_valid8, in_ready8);
    end
    repeat (2) @(negedge clock);
    resetn     = 1'b1;
    out_ready8 = 1'b1;
    in_valid8  = 1'b1;
    in_posit8  = 8'h60;
    #1;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL release_first: in_ready=%b out_valid=%b required 1 0", in_ready8, out_valid8);
    end
    @(negedge clock);
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL release_stale: out_valid=%b required 0", out_valid8);
    end
    @(negedge clock);
    checks++;
    if (out_valid8 !== 1'b1 || obs8 !== 12'h0E0) begin
      errors++;
      $display("FAIL release_result: valid=%b got %h required %h", out_valid8, obs8, 12'h0E0);
    end
    @(negedge clock);
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL release_dup: out_valid=%b required 0", out_valid8);
    end
  endtask

  task automatic test_random16();
    logic [15:0] specials[6];
    logic [20:0] held, want;
    logic        hold;
    int sent, got;
    specials = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h8001};
    hold = 1'b0;
    held = '0;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 460; c++) begin
      @(negedge clock);
      if (hold) begin
        checks++;
        if (out_valid16 !== 1'b1 || obs16 !== held) begin
          errors++;
          $display("FAIL rand_hold c=%0d: valid=%b got %h required %h", c, out_valid16, obs16, held);
        end
      end
      if (c < 400) begin
        out_ready16 = ($urandom_range(0, 3) != 0);
        in_valid16  = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 7) == 0)
          in_posit16 = specials[$urandom_range(0, 5)];
        else
          in_posit16 = 16'($urandom_range(0, 65535));
      end else begin
        out_ready16 = 1'b1;
        in_valid16  = 1'b0;
      end
      #1;
      hold = out_valid16 && !out_ready16;
      held = obs16;
      if (out_valid16 && out_ready16) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got %h required none", obs16);
        end else begin
          want = exp_q.pop_front();
          if (obs16 !== want) begin
            errors++;
            $display("FAIL rand_data[%0d]: got %h required %h", got, obs16, want);
          end
        end
        got++;
      end
      if (in_valid16 && in_ready16) begin
        exp_q.push_back(ref16(in_posit16));
        sent++;
      end
    end
    checks++;
    if (exp_q.size() != 0 || got != sent || sent == 0) begin
      errors++;
      $display("FAIL rand_drain: sent=%0d got=%0d left=%0d required equal and none left", sent, got, exp_q.size());
    end
  endtask

  initial begin
    resetn      = 1'b0;
    in_valid8   = 1'b0;
    in_posit8   = '0;
    out_ready8  = 1'b0;
    in_valid16  = 1'b0;
    in_posit16  = '0;
    out_ready16 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_extremes();
    test_stall();
    test_reset_midflight();
    test_random16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
